fma16_out_stage: RTL and testbench

//   Buffered output stage that consumes each finished fma16 result word and its exception bits.

---
 rtl/fma16_out_stage.sv | 182 ++++++++++++++++++
 tb/tb_fma16_out_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fma16_out_stage.sv
// -----------------------------------------------------------------------------
// fma16_out_stage
//
// Buffered output stage for the fma16 datapath. It accepts each finished
// half-precision result and its exception bits. NaNs are canonicalised on the
// way in. Results are kept in order in a DEPTH-entry FIFO and offered
// downstream with a valid/ready handshake. The stage also keeps sticky
// exception flags and a saturating count of inexact results.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready = FIFO not full)
//   in_mult             half-precision result {sign, exp[4:0], mant[9:0]}
//   in_nx/uf/of/nv      exception bits of the incoming result
//   out_valid/out_ready downstream handshake for the FIFO head
//   out_mult/out_flags  head result word and flags {nv, of, uf, nx}
//   flags_sticky        accumulated {nv, of, uf, nx}
//   flags_clr           synchronous clear of sticky flags and nx_count
//   nx_count            saturating count of accepted results with nx=1
//   level               current FIFO occupancy
// -----------------------------------------------------------------------------
module fma16_out_stage #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [15:0]              in_mult,
   input  logic                     in_nx,
   input  logic                     in_uf,
   input  logic                     in_of,
   input  logic                     in_nv,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [15:0]              out_mult,
   output logic [3:0]               out_flags,
   output logic [3:0]               flags_sticky,
   input  logic                     flags_clr,
   output logic [CNT_W-1:0]         nx_count,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = $clog2(DEPTH) + 1;
   localparam logic [15:0] CanonicalNan = 16'h7E00;

   // Stored entry layout: {flags[3:0], mult[15:0]}
   typedef logic [19:0] entry_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   entry_t              mem_q [DEPTH];
   entry_t              mem_d [DEPTH];
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]     level_q, level_d;
   logic [3:0]          sticky_q, sticky_d;
   logic [CNT_W-1:0]    count_q, count_d;
   // Holds in_ready low while reset is asserted and for no longer: it rises on
   // the first clock edge after release, so in_ready stays a function of
   // registered state only.
   logic                ready_en_q;

   // ---------------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------------
   logic push;
   logic pop;
   logic full;
   logic empty;

   assign full      = (level_q == LvlW'(DEPTH));
   assign empty     = (level_q == '0);
   assign in_ready  = ready_en_q & ~full;
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // ---------------------------------------------------------------------------
   // Entry transform applied before the write
   // ---------------------------------------------------------------------------
   logic        in_is_nan;
   logic [15:0] st_mult;
   logic [3:0]  st_flags;
   entry_t      st_entry;

   always_comb begin
      in_is_nan = (in_mult[14:10] == 5'h1F) && (in_mult[9:0] != 10'd0);
      // Invalid operations and every NaN encoding collapse to one positive qNaN.
      st_mult   = (in_nv || in_is_nan) ? CanonicalNan : in_mult;
      // Overflow and underflow always imply an inexact result.
      st_flags  = {in_nv, in_of, in_uf, (in_nx | in_of | in_uf)};
      st_entry  = {st_flags, st_mult};
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      sticky_d = sticky_q;
      count_d  = count_q;

      // The write is gated by push, so an X on in_* with in_valid low
      // never reaches state.
      if (push) begin
         mem_d[wr_ptr_q] = st_entry;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase

      // The clear applies first. A push in the same cycle then sets bits from zero.
      if (flags_clr) begin
         sticky_d = 4'b0000;
         count_d  = '0;
      end

      if (push) begin
         sticky_d = sticky_d | st_flags;
         if (st_flags[0] && (count_d != {CNT_W{1'b1}})) begin
            count_d = count_d + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         sticky_q   <= 4'b0000;
         count_q    <= '0;
         ready_en_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         sticky_q   <= sticky_d;
         count_q    <= count_d;
         ready_en_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   entry_t head;

   always_comb begin
      head      = mem_q[rd_ptr_q];
      // Drive zeros when empty rather than a stale entry.
      out_mult  = out_valid ? head[15:0]  : 16'h0000;
      out_flags = out_valid ? head[19:16] : 4'b0000;
   end

   assign flags_sticky = sticky_q;
   assign nx_count     = count_q;
   assign level        = level_q;

endmodule

// File: tb/tb_fma16_out_stage.sv
module tb_fma16_out_stage;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_mult;
   logic        in_nx, in_uf, in_of, in_nv;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_mult;
   logic [3:0]  out_flags;
   logic [3:0]  flags_sticky;
   logic        flags_clr;
   logic [7:0]  nx_count;
   logic [1:0]  level;

   int n_checks = 0;
   int n_fail   = 0;

   fma16_out_stage #(
      .DEPTH (2),
      .CNT_W (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_mult      (in_mult),
      .in_nx        (in_nx),
      .in_uf        (in_uf),
      .in_of        (in_of),
      .in_nv        (in_nv),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_mult     (out_mult),
      .out_flags    (out_flags),
      .flags_sticky (flags_sticky),
      .flags_clr    (flags_clr),
      .nx_count     (nx_count),
      .level        (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample and drive 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] m, input logic nv, input logic of,
                        input logic uf, input logic nx);
      in_valid = v;
      in_mult  = m;
      in_nv    = nv;
      in_of    = of;
      in_uf    = uf;
      in_nx    = nx;
   endtask

   initial begin
      reset_n   = 1'b0;
      out_ready = 1'b0;
      flags_clr = 1'b0;
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---- Reset state ----
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_sticky", flags_sticky, 0);
      chk("rst_count", nx_count, 0);
      reset_n = 1'b1;
      #1;
      chk("rel_in_ready_same_cycle", in_ready, 0);

      // ---- 1: single push and pop ----
      tick();
      chk("t1_in_ready_after_rel", in_ready, 1);
      out_ready = 1'b1;
      drive(1'b1, 16'h3C00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_mult", out_mult, 16'h3C00);
      chk("t1_out_flags", out_flags, 4'b0000);
      chk("t1_level", level, 1);
      drive(1'b0, 16'hxxxx, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t1_level_drained", level, 0);
      chk("t1_out_valid_empty", out_valid, 0);
      chk("t1_out_mult_empty", out_mult, 16'h0000);
      tick();
      chk("x_idle_level", level, 0);
      chk("x_idle_sticky", flags_sticky, 0);

      // ---- 2: fill, stall, ordered drain, simultaneous push/pop ----
      out_ready = 1'b0;
      drive(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t2_level1", level, 1);
      drive(1'b1, 16'h4200, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t2_level2", level, 2);
      chk("t2_in_ready_full", in_ready, 0);
      chk("t2_head_4000", out_mult, 16'h4000);
      drive(1'b1, 16'h4400, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t2_stall_level", level, 2);
      chk("t2_stall_head", out_mult, 16'h4000);
      out_ready = 1'b1;
      tick();
      chk("t2_pop1_head", out_mult, 16'h4200);
      chk("t2_pop1_level", level, 1);
      chk("t2_pop1_in_ready", in_ready, 1);
      tick();
      chk("t2_pushpop_level", level, 1);
      chk("t2_pushpop_head", out_mult, 16'h4400);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t2_drained", level, 0);

      // ---- 3: NaN canonicalisation ----
      drive(1'b1, 16'hFE01, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t3_nan_mult", out_mult, 16'h7E00);
      chk("t3_nan_flags", out_flags, 4'b0000);
      drive(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t3_nv_mult", out_mult, 16'h7E00);
      chk("t3_nv_flags", out_flags, 4'b1000);
      drive(1'b1, 16'hFC00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t3_inf_kept", out_mult, 16'hFC00);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t3_sticky_nv", flags_sticky, 4'b1000);
      flags_clr = 1'b1;
      tick();
      flags_clr = 1'b0;
      chk("t3_clr_sticky", flags_sticky, 4'b0000);

      // ---- 4: of forces nx; clear together with push ----
      drive(1'b1, 16'h7C00, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("t4_of_flags", out_flags, 4'b0101);
      chk("t4_of_sticky", flags_sticky, 4'b0101);
      chk("t4_of_count", nx_count, 1);
      flags_clr = 1'b1;
      drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      flags_clr = 1'b0;
      chk("t4_clrpush_sticky", flags_sticky, 4'b0011);
      chk("t4_clrpush_count", nx_count, 1);
      chk("t4_clrpush_flags", out_flags, 4'b0011);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t4_drained", level, 0);

      // ---- 5: nx_count saturation (starts at 1) ----
      drive(1'b1, 16'h3555, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 200; i++) tick();
      chk("t5_count_201", nx_count, 8'hC9);
      for (int i = 0; i < 54; i++) tick();
      chk("t5_count_sat", nx_count, 8'hFF);
      for (int i = 0; i < 46; i++) tick();
      chk("t5_count_hold", nx_count, 8'hFF);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t5_sticky", flags_sticky, 4'b0011);
      chk("t5_drained", level, 0);

      // ---- 6: asynchronous reset mid-pop with FIFO full ----
      out_ready = 1'b0;
      drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_full", level, 2);
      out_ready = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_async_out_valid", out_valid, 0);
      chk("t6_async_level", level, 0);
      chk("t6_async_sticky", flags_sticky, 0);
      chk("t6_async_count", nx_count, 0);
      chk("t6_async_in_ready", in_ready, 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("t6_rel_in_ready", in_ready, 1);
      chk("t6_rel_out_valid", out_valid, 0);
      drive(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_first_out", out_mult, 16'h3333);
      chk("t6_first_level", level, 1);
      tick();
      chk("t6_final_level", level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
